// File: rtl/sprite_anim_pkg.sv
// Shared types and constants for the battle sprite animation blocks.
package sprite_anim_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRAW,
    ST_WAIT_FRAME,
    ST_ERASE,
    ST_STEP,
    ST_DONE
  } anim_state_t;

  localparam logic DRAW_OP  = 1'b0;
  localparam logic ERASE_OP = 1'b1;

  localparam int DEF_X_W = 9;
  localparam int DEF_Y_W = 8;

endpackage

// File: rtl/frame_tick_gen.sv
// Animation frame timebase: one-cycle tick every FRAME_DIV enabled cycles.
module frame_tick_gen #(
  parameter int FRAME_DIV = 833334
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int CNT_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_DIV - 1);

  logic [CNT_W-1:0] count;

  assign tick = enable && !clear && (count == LAST);

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= (count == LAST) ? '0 : count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/sprite_dash_animator.sv
// Dash-attack animator: moves a sprite out from home and back NUM_PASSES times,
// issuing one erase/draw pair to the sprite drawer per animation frame.
module sprite_dash_animator
  import sprite_anim_pkg::*;
#(
  parameter int X_W        = DEF_X_W,
  parameter int Y_W        = DEF_Y_W,
  parameter int HOME_X     = 50,
  parameter int HOME_Y     = 120,
  parameter int DASH_DIST  = 25,
  parameter int STEP       = 1,
  parameter int NUM_PASSES = 2,
  parameter int FRAME_DIV  = 833334
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  input  logic            dir_left,
  input  logic            abort,
  input  logic            draw_done,
  output logic            draw_req,
  output logic            draw_erase,
  output logic [X_W-1:0]  sprite_x,
  output logic [Y_W-1:0]  sprite_y,
  output logic            busy,
  output logic            done,
  output anim_state_t     dbg_state
);

  localparam int PASS_W = (NUM_PASSES > 0) ? $clog2(NUM_PASSES + 1) : 1;
  localparam logic [X_W-1:0]    HOME_X_C = X_W'(HOME_X);
  localparam logic [X_W-1:0]    DIST_C   = X_W'(DASH_DIST);
  localparam logic [X_W-1:0]    STEP_C   = X_W'(STEP);
  localparam logic [PASS_W-1:0] PASSES_C = PASS_W'(NUM_PASSES);

  anim_state_t       state, state_next;
  logic [X_W-1:0]    offset, offset_next;
  logic [PASS_W-1:0] pass_cnt, pass_next;
  logic              outbound, outbound_next;
  logic              aborting, abort_now;
  logic              dir_left_q;
  logic              tick_pending;
  logic              tick;
  logic              finished;

  frame_tick_gen #(
    .FRAME_DIV(FRAME_DIV)
  ) u_frame_tick (
    .clock (clock),
    .reset (reset),
    .clear (state == ST_IDLE),
    .enable(busy),
    .tick  (tick)
  );

  assign finished  = (offset == '0) && ((pass_cnt == PASSES_C) || aborting);
  assign abort_now = aborting || abort;
  assign sprite_x  = dir_left_q ? (HOME_X_C - offset) : (HOME_X_C + offset);
  assign sprite_y  = Y_W'(HOME_Y);
  assign dbg_state = state;

  // Handshake: draw_req rises with the request and holds (with draw_erase and
  // sprite_x/y stable) until the drawer returns a one-cycle draw_done; the
  // request drops the following cycle. draw_done seen while no request is
  // pending has no effect.
  always_comb begin
    state_next = state;
    draw_req   = 1'b0;
    draw_erase = DRAW_OP;
    busy       = (state != ST_IDLE);
    done       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) state_next = ST_DRAW;
      end
      ST_DRAW: begin
        draw_req = 1'b1;
        if (draw_done) state_next = finished ? ST_DONE : ST_WAIT_FRAME;
      end
      ST_WAIT_FRAME: begin
        if (tick_pending || tick) state_next = ST_ERASE;
      end
      ST_ERASE: begin
        draw_req   = 1'b1;
        draw_erase = ERASE_OP;
        if (draw_done) state_next = ST_STEP;
      end
      ST_STEP: begin
        state_next = ST_DRAW;
      end
      ST_DONE: begin
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Abort at home (offset 0) holds position so the next draw simply finishes.
  always_comb begin
    offset_next   = offset;
    pass_next     = pass_cnt;
    outbound_next = outbound;
    if (outbound && !abort_now) begin
      offset_next   = offset + STEP_C;
      outbound_next = (offset_next != DIST_C);
    end else if (offset == '0) begin
      outbound_next = 1'b0;
    end else begin
      offset_next = offset - STEP_C;
      if (offset_next == '0) begin
        pass_next     = pass_cnt + PASS_W'(1);
        outbound_next = 1'b1;
      end else begin
        outbound_next = 1'b0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= ST_IDLE;
      offset       <= '0;
      pass_cnt     <= '0;
      outbound     <= 1'b1;
      aborting     <= 1'b0;
      dir_left_q   <= 1'b0;
      tick_pending <= 1'b0;
    end else begin
      state <= state_next;

      if (state == ST_IDLE || state == ST_WAIT_FRAME) begin
        tick_pending <= 1'b0;
      end else if (tick) begin
        tick_pending <= 1'b1;
      end

      if (state == ST_IDLE && start) begin
        dir_left_q <= dir_left;
        offset     <= '0;
        pass_cnt   <= '0;
        outbound   <= 1'b1;
        aborting   <= 1'b0;
      end else if (state == ST_STEP) begin
        offset   <= offset_next;
        pass_cnt <= pass_next;
        outbound <= outbound_next;
        aborting <= abort_now;
      end
    end
  end

endmodule

// File: tb/tb_sprite_dash_animator.sv
// Directed bench for sprite_dash_animator: two instances (one and two passes)
// driven by a drawer model that acknowledges each request after ack_lat cycles.
module tb_sprite_dash_animator;
  import sprite_anim_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        dir_left = 1'b0;
  logic        abort = 1'b0;
  logic        start [2];
  logic        draw_done [2];
  logic        draw_req [2];
  logic        draw_erase [2];
  logic [8:0]  sprite_x [2];
  logic [7:0]  sprite_y [2];
  logic        busy [2];
  logic        done [2];
  anim_state_t dbg_state [2];

  int n_cmp = 0;
  int n_err = 0;
  int ack_lat = 2;
  int ack_cnt [2];
  int done_cnt [2];

  logic [9:0] log_q [$];
  logic [7:0] y_q [$];
  logic [9:0] exp_q [$];

  sprite_dash_animator #(
    .X_W(9), .Y_W(8), .HOME_X(50), .HOME_Y(120), .DASH_DIST(3),
    .STEP(1), .NUM_PASSES(1), .FRAME_DIV(4)
  ) u0 (
    .clock(clock), .reset(reset), .start(start[0]), .dir_left(dir_left),
    .abort(abort), .draw_done(draw_done[0]), .draw_req(draw_req[0]),
    .draw_erase(draw_erase[0]), .sprite_x(sprite_x[0]), .sprite_y(sprite_y[0]),
    .busy(busy[0]), .done(done[0]), .dbg_state(dbg_state[0])
  );

  sprite_dash_animator #(
    .X_W(9), .Y_W(8), .HOME_X(50), .HOME_Y(120), .DASH_DIST(3),
    .STEP(1), .NUM_PASSES(2), .FRAME_DIV(4)
  ) u1 (
    .clock(clock), .reset(reset), .start(start[1]), .dir_left(dir_left),
    .abort(abort), .draw_done(draw_done[1]), .draw_req(draw_req[1]),
    .draw_erase(draw_erase[1]), .sprite_x(sprite_x[1]), .sprite_y(sprite_y[1]),
    .busy(busy[1]), .done(done[1]), .dbg_state(dbg_state[1])
  );

  always #5 clock = ~clock;

  // Drawer model and transaction monitor, both on the inactive edge.
  always @(negedge clock) begin
    for (int i = 0; i < 2; i++) begin
      if (done[i]) done_cnt[i]++;
      if (draw_done[i] || !draw_req[i] || reset) begin
        draw_done[i] = 1'b0;
        ack_cnt[i]   = 0;
      end else begin
        ack_cnt[i]++;
        if (ack_cnt[i] >= ack_lat) begin
          draw_done[i] = 1'b1;
          log_q.push_back({draw_erase[i], sprite_x[i]});
          y_q.push_back(sprite_y[i]);
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic pulse_start(input int idx);
    @(negedge clock);
    start[idx] = 1'b1;
    @(negedge clock);
    start[idx] = 1'b0;
  endtask

  task automatic wait_done(input int idx, input string tag);
    int c;
    c = 0;
    while (!done[idx] && c < 2000) begin
      @(negedge clock);
      c++;
    end
    check(tag, 32'(done[idx]), 32'd1);
    cycles(3);
  endtask

  // Expected draw/erase stream for a list of draw positions: each draw except
  // the last is followed by an erase at the same position.
  task automatic build_exp(input int xs [$]);
    exp_q.delete();
    for (int i = 0; i < xs.size(); i++) begin
      exp_q.push_back({DRAW_OP, 9'(xs[i])});
      if (i < xs.size() - 1) exp_q.push_back({ERASE_OP, 9'(xs[i])});
    end
  endtask

  task automatic compare_log(input string tag);
    int bad_y;
    int n;
    check({tag, ".len"}, 32'(log_q.size()), 32'(exp_q.size()));
    n = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s.op%0d", tag, i), 32'(log_q[i]), 32'(exp_q[i]));
    bad_y = 0;
    foreach (y_q[i]) if (y_q[i] !== 8'd120) bad_y++;
    check({tag, ".y_bad"}, 32'(bad_y), 32'd0);
  endtask

  function automatic int count_ops(input logic op);
    int c;
    c = 0;
    foreach (log_q[i]) if (log_q[i][9] == op) c++;
    return c;
  endfunction

  task automatic clear_logs();
    log_q.delete();
    y_q.delete();
    done_cnt[0] = 0;
    done_cnt[1] = 0;
  endtask

  initial begin
    int xs [$];
    int c;
    start[0] = 1'b0; start[1] = 1'b0;
    draw_done[0] = 1'b0; draw_done[1] = 1'b0;
    ack_cnt[0] = 0; ack_cnt[1] = 0;
    done_cnt[0] = 0; done_cnt[1] = 0;

    cycles(3);
    reset = 1'b0;
    cycles(1);
    check("rst.draw_req", 32'(draw_req[0]), 32'd0);
    check("rst.draw_erase", 32'(draw_erase[0]), 32'd0);
    check("rst.busy", 32'(busy[0]), 32'd0);
    check("rst.done", 32'(done[0]), 32'd0);
    check("rst.sprite_x", 32'(sprite_x[0]), 32'd50);
    check("rst.sprite_y", 32'(sprite_y[0]), 32'd120);
    check("rst.state", 32'(dbg_state[0]), 32'(ST_IDLE));
    check("rst.busy_u1", 32'(busy[1]), 32'd0);

    // Right dash
    clear_logs();
    dir_left = 1'b0;
    pulse_start(0);
    check("right.busy_rise", 32'(busy[0]), 32'd1);
    wait_done(0, "right.done_seen");
    xs = '{50, 51, 52, 53, 52, 51, 50};
    build_exp(xs);
    compare_log("right");
    check("right.done_cnt", 32'(done_cnt[0]), 32'd1);
    check("right.busy_after", 32'(busy[0]), 32'd0);
    check("right.x_home", 32'(sprite_x[0]), 32'd50);

    // Left dash
    clear_logs();
    dir_left = 1'b1;
    pulse_start(0);
    dir_left = 1'b0;
    wait_done(0, "left.done_seen");
    xs = '{50, 49, 48, 47, 48, 49, 50};
    build_exp(xs);
    compare_log("left");
    check("left.done_cnt", 32'(done_cnt[0]), 32'd1);

    // Two round trips
    clear_logs();
    pulse_start(1);
    wait_done(1, "pass2.done_seen");
    xs = '{50, 51, 52, 53, 52, 51, 50, 51, 52, 53, 52, 51, 50};
    build_exp(xs);
    compare_log("pass2");
    check("pass2.draws", 32'(count_ops(DRAW_OP)), 32'd13);
    check("pass2.erases", 32'(count_ops(ERASE_OP)), 32'd12);
    check("pass2.done_cnt", 32'(done_cnt[1]), 32'd1);
    check("pass2.busy_after", 32'(busy[1]), 32'd0);

    // Abort after the draw at x=52
    clear_logs();
    pulse_start(0);
    c = 0;
    while (log_q.size() < 5 && c < 1000) begin
      @(negedge clock);
      c++;
    end
    check("abort.reach52", 32'(log_q.size() >= 5), 32'd1);
    abort = 1'b1;
    wait_done(0, "abort.done_seen");
    abort = 1'b0;
    xs = '{50, 51, 52, 51, 50};
    build_exp(xs);
    compare_log("abort");
    check("abort.done_cnt", 32'(done_cnt[0]), 32'd1);

    // Slow drawer: ticks arrive while a request is pending
    clear_logs();
    ack_lat = 10;
    pulse_start(0);
    cycles(25);
    pulse_start(0);
    check("slow.busy_mid", 32'(busy[0]), 32'd1);
    wait_done(0, "slow.done_seen");
    xs = '{50, 51, 52, 53, 52, 51, 50};
    build_exp(xs);
    compare_log("slow");
    check("slow.draws", 32'(count_ops(DRAW_OP)), 32'd7);
    cycles(5);
    check("slow.no_restart", 32'(busy[0]), 32'd0);
    check("slow.done_cnt", 32'(done_cnt[0]), 32'd1);
    ack_lat = 2;

    // Reset during ERASE, then a clean run
    clear_logs();
    pulse_start(0);
    c = 0;
    while (dbg_state[0] != ST_ERASE && c < 1000) begin
      @(negedge clock);
      c++;
    end
    check("rstmid.reach_erase", 32'(dbg_state[0] == ST_ERASE), 32'd1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("rstmid.draw_req", 32'(draw_req[0]), 32'd0);
    check("rstmid.busy", 32'(busy[0]), 32'd0);
    check("rstmid.sprite_x", 32'(sprite_x[0]), 32'd50);
    cycles(3);
    clear_logs();
    pulse_start(0);
    wait_done(0, "rstmid.done_seen");
    xs = '{50, 51, 52, 53, 52, 51, 50};
    build_exp(xs);
    compare_log("rstmid");
    check("rstmid.done_cnt", 32'(done_cnt[0]), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
